// File: rtl/axi_master_pkg.sv
// Shared types for the AXI burst master: response codes, channel FSM states,
// and a helper that picks the more severe of two responses.
package axi_master_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_e;

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/burst_beat_ctr.sv
// Beat counter for one channel: latches the burst length on load, counts
// beats without wrapping, and flags the last and past-the-end beat.
module burst_beat_ctr #(
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic [LEN_W-1:0] len,
    output logic [LEN_W:0]   cnt,
    output logic             last_c,
    output logic             over_c
);

    localparam int unsigned CW = LEN_W + 1;

    logic [LEN_W-1:0] len_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            len_q <= '0;
        end else if (load) begin
            cnt   <= '0;
            len_q <= len;
        end else if (inc && (cnt != {CW{1'b1}})) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign last_c = (cnt == {1'b0, len_q});
    assign over_c = (cnt >  {1'b0, len_q});

endmodule

// File: rtl/axi_burst_master.sv
// AXI-style burst master with independent read and write channels; each
// channel runs its own FSM and beat counter and reports a final response.
module axi_burst_master
    import axi_master_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned LEN_W  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rd_start,
    input  logic                              wr_start,
    input  logic [ADDR_W-1:0]                 cmd_addr,
    input  logic [LEN_W-1:0]                  cmd_len,
    input  logic [ID_W-1:0]                   cmd_id,
    input  logic [(2**LEN_W)*DATA_W-1:0]      wr_buf,
    output logic [(2**LEN_W)*DATA_W-1:0]      rd_buf,
    output logic                              rd_busy,
    output logic                              wr_busy,
    output logic                              rd_done,
    output logic                              wr_done,
    output logic [1:0]                        rd_resp,
    output logic [1:0]                        wr_resp,
    output logic                              arvalid,
    input  logic                              arready,
    output logic [ADDR_W+LEN_W+ID_W-1:0]      ar_payload,
    input  logic                              rvalid,
    output logic                              rready,
    input  logic [DATA_W-1:0]                 rdata,
    input  logic [1:0]                        rresp,
    input  logic                              rlast,
    output logic                              awvalid,
    input  logic                              awready,
    output logic [ADDR_W+LEN_W+ID_W-1:0]      aw_payload,
    output logic                              wvalid,
    input  logic                              wready,
    output logic [DATA_W-1:0]                 wdata,
    output logic                              wlast,
    input  logic                              bvalid,
    output logic                              bready,
    input  logic [1:0]                        bresp
);

    localparam int unsigned NB = 2**LEN_W;
    localparam int unsigned CW = LEN_W + 1;

    rd_state_e        rd_state, rd_next;
    wr_state_e        wr_state, wr_next;
    logic [CW-1:0]    rd_cnt, wr_cnt;
    logic             rd_last_c, rd_over_c, wr_last_c, wr_over_c;
    logic             rd_start_c, rd_beat_c, rd_bad_c;
    logic             wr_start_c, wr_beat_c;
    logic [1:0]       rd_max_c;
    logic [1:0]       rd_resp_max;
    logic             rd_err;
    logic [NB*DATA_W-1:0] wr_snap;

    assign rd_start_c = (rd_state == R_IDLE) && rd_start;
    assign rd_beat_c  = (rd_state == R_DATA) && rvalid;
    assign wr_start_c = (wr_state == W_IDLE) && wr_start;
    assign wr_beat_c  = (wr_state == W_DATA) && wready;

    burst_beat_ctr #(.LEN_W(LEN_W)) u_rd_ctr (
        .clk(clk), .rst(rst), .load(rd_start_c), .inc(rd_beat_c), .len(cmd_len),
        .cnt(rd_cnt), .last_c(rd_last_c), .over_c(rd_over_c)
    );

    burst_beat_ctr #(.LEN_W(LEN_W)) u_wr_ctr (
        .clk(clk), .rst(rst), .load(wr_start_c), .inc(wr_beat_c && !wr_last_c), .len(cmd_len),
        .cnt(wr_cnt), .last_c(wr_last_c), .over_c(wr_over_c)
    );

    // Read channel FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_state <= R_IDLE;
        else     rd_state <= rd_next;
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (rd_start) rd_next = R_ADDR;
            R_ADDR:  if (arready)  rd_next = R_DATA;
            R_DATA:  if (rvalid && rlast) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        arvalid = (rd_state == R_ADDR);
        rready  = (rd_state == R_DATA);
        rd_busy = (rd_state != R_IDLE);
    end

    // Early rlast, or any beat past the latched length, marks the burst as failed
    assign rd_max_c = resp_max(rd_resp_max, rresp);
    assign rd_bad_c = rd_err || rd_over_c || (rlast && !rd_last_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_payload  <= '0;
            rd_buf      <= '0;
            rd_resp     <= RESP_OKAY;
            rd_resp_max <= RESP_OKAY;
            rd_err      <= 1'b0;
            rd_done     <= 1'b0;
        end else begin
            rd_done <= rd_beat_c && rlast;
            if (rd_start_c) begin
                ar_payload  <= {cmd_addr, cmd_len, cmd_id};
                rd_buf      <= '0;
                rd_resp     <= RESP_OKAY;
                rd_resp_max <= RESP_OKAY;
                rd_err      <= 1'b0;
            end else if (rd_beat_c) begin
                rd_resp_max <= rd_max_c;
                rd_err      <= rd_bad_c;
                rd_resp     <= rd_bad_c ? RESP_SLVERR : rd_max_c;
                if (!rd_over_c) begin
                    for (int k = 0; k < NB; k++) begin
                        if (rd_cnt == CW'(k)) rd_buf[k*DATA_W +: DATA_W] <= rdata;
                    end
                end
            end
        end
    end

    // Write channel FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_state <= W_IDLE;
        else     wr_state <= wr_next;
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:  if (wr_start) wr_next = W_ADDR;
            W_ADDR:  if (awready)  wr_next = W_DATA;
            W_DATA:  if (wready && (wr_last_c || wr_over_c)) wr_next = W_RESP;
            W_RESP:  if (bvalid)   wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        awvalid = (wr_state == W_ADDR);
        wvalid  = (wr_state == W_DATA);
        bready  = (wr_state == W_RESP);
        wr_busy = (wr_state != W_IDLE);
        wlast   = (wr_state == W_DATA) && wr_last_c;
        wdata   = '0;
        if (wr_state == W_DATA) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_cnt == CW'(k)) wdata = wr_snap[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_payload <= '0;
            wr_snap    <= '0;
            wr_resp    <= RESP_OKAY;
            wr_done    <= 1'b0;
        end else begin
            wr_done <= (wr_state == W_RESP) && bvalid;
            if (wr_start_c) begin
                aw_payload <= {cmd_addr, cmd_len, cmd_id};
                wr_snap    <= wr_buf;
                wr_resp    <= RESP_OKAY;
            end else if ((wr_state == W_RESP) && bvalid) begin
                wr_resp <= bresp;
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: single bursts, stalls, concurrent
// 16-beat bursts, protocol errors on read, and reset mid-write.
module tb_axi_burst_master;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_start, wr_start;
    logic [7:0]   cmd_addr;
    logic [3:0]   cmd_len, cmd_id;
    logic [127:0] wr_buf, rd_buf;
    logic         rd_busy, wr_busy, rd_done, wr_done;
    logic [1:0]   rd_resp, wr_resp;
    logic         arvalid, arready, rvalid, rready, rlast;
    logic [15:0]  ar_payload, aw_payload;
    logic [7:0]   rdata, wdata;
    logic [1:0]   rresp, bresp;
    logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;

    int n_checks = 0;
    int n_errors = 0;
    int rd_done_cnt = 0;
    int wr_done_cnt = 0;

    logic [7:0] wb_data [0:31];
    logic       wb_last [0:31];
    int         wb_n;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rd_done) rd_done_cnt++;
        if (wr_done) wr_done_cnt++;
    end

    axi_burst_master dut (
        .clk(clk), .rst(rst), .rd_start(rd_start), .wr_start(wr_start),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wr_buf(wr_buf), .rd_buf(rd_buf),
        .rd_busy(rd_busy), .wr_busy(wr_busy), .rd_done(rd_done), .wr_done(wr_done),
        .rd_resp(rd_resp), .wr_resp(wr_resp),
        .arvalid(arvalid), .arready(arready), .ar_payload(ar_payload),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .aw_payload(aw_payload),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_slave(input int nbeats, input int stall, input logic [7:0] base, input int ex_beat);
        int t = 0;
        while (!arvalid && t < 20) begin step(); t++; end
        check("rd_ar_seen", arvalid, 1'b1);
        repeat ($urandom_range(0, 2)) step();
        arready = 1'b1; step(); arready = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            while ($urandom_range(0, 99) < stall) begin rvalid = 1'b0; step(); end
            rvalid = 1'b1;
            rdata  = base + 8'(i);
            rresp  = (i == ex_beat) ? 2'd1 : 2'd0;
            rlast  = (i == nbeats - 1);
            step();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic wr_slave(input int stall, input logic [1:0] br);
        int   t = 0;
        logic hs;
        bit   early = 1'b0;
        wb_n = 0;
        while (!awvalid && t < 20) begin step(); t++; end
        check("wr_aw_seen", awvalid, 1'b1);
        repeat ($urandom_range(0, 2)) begin
            if (wvalid) early = 1'b1;
            step();
        end
        if (wvalid) early = 1'b1;
        awready = 1'b1; step(); awready = 1'b0;
        check("w_before_aw", early, 1'b0);
        t = 0;
        while (t < 200 && wb_n < 32) begin
            wready = ($urandom_range(0, 99) >= stall);
            hs = wvalid && wready;
            if (hs) begin
                wb_data[wb_n] = wdata;
                wb_last[wb_n] = wlast;
            end
            step();
            t++;
            if (hs) begin
                wb_n++;
                if (wb_last[wb_n-1]) break;
            end
        end
        wready = 1'b0;
        repeat ($urandom_range(0, 2)) step();
        check("wr_bready", bready, 1'b1);
        bvalid = 1'b1; bresp = br; step(); bvalid = 1'b0;
        check("wr_done_pulse", wr_done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rd0, wr0, w_err;
        logic [127:0] exp_buf;

        rst = 1'b1;
        {rd_start, wr_start, arready, rvalid, rlast, awready, wready, bvalid} = '0;
        cmd_addr = '0; cmd_len = '0; cmd_id = '0; wr_buf = '0;
        rdata = '0; rresp = '0; bresp = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valids", {arvalid, rready, awvalid, wvalid, bready, wlast}, '0);
        check("rst_rd_buf", rd_buf, '0);
        check("rst_payloads", {ar_payload, aw_payload}, '0);
        check("rst_misc", {rd_busy, wr_busy, rd_done, wr_done, rd_resp, wr_resp, wdata}, '0);
        rst = 1'b0;
        step();

        // Read of 4 beats, arready on the second address cycle
        rd0 = rd_done_cnt;
        cmd_addr = 8'h40; cmd_len = 4'd3; cmd_id = 4'd5; rd_start = 1'b1;
        step(); rd_start = 1'b0;
        check("t1_arvalid", {arvalid, rd_busy}, 2'b11);
        check("t1_ar_payload", ar_payload, {8'h40, 4'd3, 4'd5});
        step(); arready = 1'b1;
        step(); arready = 1'b0;
        check("t1_after_ar", {arvalid, rready}, 2'b01);
        for (int i = 0; i < 4; i++) begin
            rvalid = 1'b1; rdata = 8'hA1 + 8'(i); rresp = 2'd0; rlast = (i == 3);
            step();
        end
        rvalid = 1'b0; rlast = 1'b0;
        check("t1_rd_done", {rd_done, rready}, 2'b10);
        check("t1_rd_buf", rd_buf[31:0], 32'hA4A3A2A1);
        check("t1_rd_resp", rd_resp, 2'd0);
        step();
        check("t1_done_once", rd_done_cnt - rd0, 1);

        // Single-beat write held off by wready
        wr0 = wr_done_cnt;
        cmd_addr = 8'h50; cmd_len = 4'd0; cmd_id = 4'd7;
        wr_buf = '0; wr_buf[7:0] = 8'h5C; wr_start = 1'b1;
        step(); wr_start = 1'b0; wr_buf = '1;
        check("t2_aw_only", {awvalid, wvalid}, 2'b10);
        check("t2_aw_payload", aw_payload, {8'h50, 4'd0, 4'd7});
        awready = 1'b1; step(); awready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t2_w_stall", {wvalid, wlast, wdata}, {1'b1, 1'b1, 8'h5C});
            step();
        end
        wready = 1'b1; step(); wready = 1'b0;
        check("t2_after_w", {wvalid, bready}, 2'b01);
        bvalid = 1'b1; bresp = 2'd1; step(); bvalid = 1'b0;
        check("t2_wr_done", {wr_done, wr_resp}, {1'b1, 2'd1});
        step();
        check("t2_done_once", wr_done_cnt - wr0, 1);

        // Concurrent 16-beat read and write with random stalls
        rd0 = rd_done_cnt; wr0 = wr_done_cnt;
        cmd_addr = 8'h10; cmd_len = 4'd15; cmd_id = 4'd3;
        for (int k = 0; k < 16; k++) wr_buf[k*8 +: 8] = 8'h30 + 8'(k);
        rd_start = 1'b1; wr_start = 1'b1;
        step(); rd_start = 1'b0; wr_start = 1'b0;
        check("t3_payloads", {ar_payload, aw_payload}, {8'h10, 4'hF, 4'd3, 8'h10, 4'hF, 4'd3});
        fork
            rd_slave(16, 30, 8'h80, 5);
            wr_slave(30, 2'd0);
        join
        repeat (2) step();
        for (int k = 0; k < 16; k++) exp_buf[k*8 +: 8] = 8'h80 + 8'(k);
        check("t3_rd_buf", rd_buf, exp_buf);
        check("t3_rd_resp", rd_resp, 2'd1);
        check("t3_w_count", wb_n, 16);
        w_err = 0;
        for (int k = 0; k < 16; k++)
            if ({wb_last[k], wb_data[k]} !== {(k == 15), 8'h30 + 8'(k)}) w_err++;
        check("t3_w_beats", w_err, 0);
        check("t3_wr_resp", wr_resp, 2'd0);
        check("t3_done_counts", {16'(rd_done_cnt - rd0), 16'(wr_done_cnt - wr0)}, {16'd1, 16'd1});

        // Early rlast, and a start pulse while the read is in flight
        rd0 = rd_done_cnt;
        cmd_addr = 8'h20; cmd_len = 4'd3; cmd_id = 4'd1; rd_start = 1'b1;
        step(); rd_start = 1'b0;
        arready = 1'b1; step(); arready = 1'b0;
        rvalid = 1'b1; rdata = 8'h11; rresp = 2'd0; rlast = 1'b0;
        cmd_addr = 8'h99; rd_start = 1'b1;
        step(); rd_start = 1'b0;
        check("t4_ignored_start", ar_payload, {8'h20, 4'd3, 4'd1});
        rdata = 8'h22; rlast = 1'b1;
        step(); rvalid = 1'b0; rlast = 1'b0;
        check("t4_early_last", {rd_done, rd_busy, rd_resp}, {1'b1, 1'b0, 2'b10});
        check("t4_rd_buf", rd_buf, 128'h2211);
        step();
        check("t4_no_restart", {arvalid, rd_done}, 2'b00);
        check("t4_done_once", rd_done_cnt - rd0, 1);

        // Reset during W_DATA, then a clean write
        wr0 = wr_done_cnt;
        cmd_addr = 8'h70; cmd_len = 4'd2; cmd_id = 4'd2; wr_buf = '1; wr_start = 1'b1;
        step(); wr_start = 1'b0;
        awready = 1'b1; step(); awready = 1'b0;
        check("t5_in_wdata", wvalid, 1'b1);
        rst = 1'b1;
        #1;
        check("t5_rst_async", {wvalid, wr_busy, wdata, wlast}, '0);
        repeat (2) step();
        rst = 1'b0;
        step();
        check("t5_no_done", wr_done_cnt - wr0, 0);
        cmd_addr = 8'h71; cmd_len = 4'd1; cmd_id = 4'd4;
        wr_buf = '0; wr_buf[15:0] = 16'h6261; wr_start = 1'b1;
        step(); wr_start = 1'b0;
        check("t5_aw_payload", aw_payload, {8'h71, 4'd1, 4'd4});
        wr_slave(0, 2'd3);
        check("t5_w_count", wb_n, 2);
        check("t5_w_beats", {wb_last[0], wb_data[0], wb_last[1], wb_data[1]},
              {1'b0, 8'h61, 1'b1, 8'h62});
        check("t5_wr_resp", wr_resp, 2'd3);
        step();
        check("t5_done_once", wr_done_cnt - wr0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_burst_master.md
AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 Parameters (name, default, meaning) SHALL be exactly the four below.
REQ-002 ADDR_W, 8, address width.
REQ-003 DATA_W, 8, beat data width.
REQ-004 ID_W, 4, transaction ID width.
REQ-005 LEN_W, 4, burst length field width; beats = len+1, buffer depth NB = 2**LEN_W.
REQ-006 Ports (name, direction, width, meaning) SHALL be exactly the list below.
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 rd_start  in  1  start read burst (sampled only in R_IDLE).
REQ-010 wr_start  in  1  start write burst (sampled only in W_IDLE).
REQ-011 cmd_addr  in  ADDR_W  burst start address.
REQ-012 cmd_len  in  LEN_W  beats minus one.
REQ-013 cmd_id  in  ID_W  transaction ID.
REQ-014 wr_buf  in  NB*DATA_W  write data; beat k at [k*DATA_W +: DATA_W].
REQ-015 rd_buf  out  NB*DATA_W  read data, same packing.
REQ-016 rd_busy, wr_busy  out  1 each  channel FSM not idle.
REQ-017 rd_done, wr_done  out  1 each  one-cycle completion pulse.
REQ-018 rd_resp, wr_resp  out  2 each  final burst response.
REQ-019 arvalid/arready  out/in  1  read-address handshake.
REQ-020 ar_payload  out  ADDR_W+LEN_W+ID_W  {addr,len,id}.
REQ-021 rvalid/rready  in/out  1  read-data handshake.
REQ-022 rdata, rresp, rlast  in  DATA_W, 2, 1  read beat.
REQ-023 awvalid/awready  out/in  1  write-address handshake.
REQ-024 aw_payload  out  ADDR_W+LEN_W+ID_W  {addr,len,id}.
REQ-025 wvalid/wready  out/in  1  write-data handshake.
REQ-026 wdata, wlast  out  DATA_W, 1  write beat.
REQ-027 bvalid/bready/bresp  in/out/in  1/1/2  write response.

Function
REQ-028 Read and write channels SHALL run independently and concurrently; simultaneous rd_start and wr_start SHALL both latch the same cmd_* values; a start pulse while the channel is busy SHALL be ignored.
REQ-029 A handshake SHALL complete on any rising edge where valid and ready are both 1; no valid output SHALL depend combinationally on its ready input; each payload SHALL stay stable while its valid is high.
REQ-030 Read FSM: R_IDLE -> R_ADDR (on rd_start; arvalid=1 from the next cycle) -> R_DATA (on AR handshake; arvalid=0, rready=1) -> R_IDLE (on the rlast beat; rready=0, rd_done=1 for one cycle).
REQ-031 In R_DATA, each beat k SHALL be stored to rd_buf slot k; rd_resp SHALL hold the numerically largest rresp seen in the burst; rd_buf SHALL hold its contents until the next rd_start.
REQ-032 If rlast arrives at a beat other than beat cmd_len, or a beat would exceed slot NB-1, the extra data SHALL be discarded and rd_resp SHALL be 2'b10.
REQ-033 Write FSM: W_IDLE -> W_ADDR (on wr_start; wr_buf snapshot taken on the same edge) -> W_DATA (on AW handshake; wvalid=1 with beat 0) -> W_RESP (after the last W handshake; wvalid=0, bready=1) -> W_IDLE (on B handshake; wr_resp=bresp, wr_done pulse).
REQ-034 wvalid SHALL NOT assert before the AW handshake completes; wdata SHALL advance one slot per W handshake; wlast SHALL be 1 exactly while beat index == latched len, including len=0.
REQ-035 Beat counters SHALL be LEN_W+1 bits wide and SHALL NOT wrap within a burst.

Reset
REQ-036 While rst=1: FSMs idle; all valid/ready outputs, done, busy, resp, payloads, wdata, wlast, rd_buf and the internal snapshot SHALL be 0. A mid-burst rst SHALL abort the burst immediately with no done pulse.

Structure
REQ-037 Package axi_master_pkg SHALL hold the response encodings (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3) and both FSM state enums; one sub-module, burst_beat_ctr (load, increment, last-compare), SHALL be instantiated once per channel.

Verification
REQ-038 rd_start, addr=0x40, len=3, id=5; arready on the 2nd cycle; 4 beats 0xA1..0xA4 with OKAY, rlast on beat 4 -> ar_payload={0x40,3,5}, rd_buf[31:0]=0xA4A3A2A1, rd_resp=0, one rd_done pulse.
REQ-039 wr_start, len=0, wr_buf[7:0]=0x5C; wready held low for 3 cycles -> wvalid/wdata=0x5C/wlast=1 held stable, exactly one W handshake, wr_resp=bresp.
REQ-040 Concurrent read len=15 and write len=15 with random ready/valid stalls -> all 16 beats correct on both channels; wlast only on beat 16.
REQ-041 Read len=3 with rlast on beat 2 -> rd_resp=2'b10, rd_done pulses; a second rd_start during R_DATA is ignored.
REQ-042 rst asserted during W_DATA -> wvalid=0 in the same cycle, no wr_done; a new write after reset completes normally.
